// File: rtl/mealy_fsm.sv
// Mealy 0110 serial sequence detector with a combinational match strobe.
// Define MEALY_FSM_OVERLAP_EN so the trailing 0 of one match can start the next.
module mealy_fsm (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= S0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S0;
    dout       = 1'b0;
    case (state)
      S0: state_next = din ? S0 : S1;
      S1: state_next = din ? S2 : S1;
      S2: state_next = din ? S3 : S1;
      S3: begin
        // dout follows din directly so an X/Z on din propagates unmasked
        dout = ~din & ~reset;
`ifdef MEALY_FSM_OVERLAP_EN
        state_next = din ? S0 : S1;
`else
        state_next = S0;
`endif
      end
      default: begin
        state_next = S0;
        dout       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mealy_fsm.sv
// Scoreboard bench for mealy_fsm: a bit-history model predicts every dout sample.
// Honours MEALY_FSM_OVERLAP_EN the same way the design does.
module tb_mealy_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic dout;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bit   hist[$];
  bit   exp_q[$];
  event chk;

  bit   pend_valid = 1'b0;
  bit   pend_r, pend_d, pend_match;

  mealy_fsm dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  // Match whenever the bits seen since the last reset (or consumed match) end in 011 and din is 0.
  function automatic bit predict(input bit r, input bit d);
    int n;
    n = hist.size();
    if (r || n < 3) return 1'b0;
    return (hist[n-3] == 1'b0) && (hist[n-2] == 1'b1) && (hist[n-1] == 1'b1) && (d == 1'b0);
  endfunction

  task automatic commit_edge();
    if (!pend_valid) return;
    if (pend_r) begin
      hist.delete();
    end else begin
      hist.push_back(pend_d);
`ifndef MEALY_FSM_OVERLAP_EN
      if (pend_match) hist.delete();
`endif
      while (hist.size() > 3) void'(hist.pop_front());
    end
  endtask

  task automatic check_now();
    bit e;
    #1;
    e = predict(pend_r, pend_d);
    pend_match = e;
    exp_q.push_back(e);
    ->chk;
  endtask

  task automatic apply(input bit r, input bit d);
    @(posedge clk);
    commit_edge();
    #1;
    reset = r;
    din   = d;
    pend_r = r;
    pend_d = d;
    pend_valid = 1'b1;
    check_now();
  endtask

  // Change din mid-cycle without a clock edge.
  task automatic wiggle(input bit d);
    #1;
    din = d;
    pend_d = d;
    check_now();
  endtask

  task automatic drive_seq(input bit [15:0] bits, input int unsigned len);
    for (int unsigned i = 0; i < len; i++) apply(1'b0, bits[len-1-i]);
  endtask

  initial begin : monitor
    bit e;
    forever begin
      @chk;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: dout=%b with no expected value queued", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          miscompares++;
          $display("FAIL dout t=%0t: actual %b required %b (reset=%b din=%b)", $time, dout, e, reset, din);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit r, d;
    // Reset held with random din
    apply(1'b1, 1'($urandom));
    apply(1'b1, 1'($urandom));
    // Basic match
    drive_seq(16'b0110, 4);
    apply(1'b1, 1'b0);
    // Overlap pattern
    drive_seq(16'b0110110, 7);
    apply(1'b1, 1'b0);
    // Near-miss, then 110 which only matches if the final state was S1
    drive_seq(16'b11101110, 8);
    drive_seq(16'b110, 3);
    // Reset mid-sequence discards the partial 011
    drive_seq(16'b011, 3);
    apply(1'b1, 1'b0);
    apply(1'b0, 1'b0);
    drive_seq(16'b110, 3);
    // Reset in S3 with din=0 masks dout
    drive_seq(16'b011, 3);
    apply(1'b1, 1'b0);
    // Mealy behaviour: in S3, din 1->0->1 between edges
    drive_seq(16'b011, 3);
    apply(1'b0, 1'b1);
    wiggle(1'b0);
    wiggle(1'b1);
    apply(1'b1, 1'b0);
    // Randomised stream biased towards 0110 fragments
    for (int unsigned i = 0; i < 3000; i++) begin
      r = ($urandom_range(63) == 0);
      d = ($urandom_range(3) != 0) ? 1'($urandom) : ((i % 4 == 1 || i % 4 == 2) ? 1'b1 : 1'b0);
      apply(r, d);
    end
    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
